// File: rtl/countdown_timer.sv
// BCD countdown timer (SS:CC, 10 ms resolution) with load/start/pause control and expiry flag.
// Optional: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry and keep running.
module countdown_timer #(
    parameter int TICK_DIV = 1000000,
    parameter int CNT_W    = 20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cd_en,
    input  logic       i_load,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic [2:0] i_load_sec_h,
    input  logic [3:0] i_load_sec_l,
    input  logic [3:0] i_load_msec_h,
    input  logic [3:0] i_load_msec_l,
    output logic [2:0] o_time_sec_h,
    output logic [3:0] o_time_sec_l,
    output logic [3:0] o_time_msec_h,
    output logic [3:0] o_time_msec_l,
    output logic       o_clk_out,
    output logic       o_time_out,
    output logic       o_load_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_div;
    logic [2:0]       r_sec_h, r_pre_sec_h;
    logic [3:0]       r_sec_l, r_msec_h, r_msec_l;
    logic [3:0]       r_pre_sec_l, r_pre_msec_h, r_pre_msec_l;
    logic             r_clk_out, r_time_out, r_load_err;

    logic             w_load_ok, w_load_bad, w_is_zero, w_is_one;
    logic             w_count, w_wrap, w_expire, w_start_idle;
    logic [2:0]       w_dec_sh;
    logic [3:0]       w_dec_sl, w_dec_mh, w_dec_ml;
    logic             w_b0, w_b1, w_b2;

    logic [CNT_W-1:0] w_div_next;
    logic [2:0]       w_sec_h_next;
    logic [3:0]       w_sec_l_next, w_msec_h_next, w_msec_l_next;
    logic             w_clk_out_next, w_time_out_next;

    assign w_load_ok  = i_load && (i_load_sec_h <= 3'd5) && (i_load_sec_l <= 4'd9)
                        && (i_load_msec_h <= 4'd9) && (i_load_msec_l <= 4'd9);
    assign w_load_bad = i_load && !w_load_ok;
    assign w_is_zero  = (r_sec_h == 3'd0) && (r_sec_l == 4'd0) && (r_msec_h == 4'd0) && (r_msec_l == 4'd0);
    assign w_is_one   = (r_sec_h == 3'd0) && (r_sec_l == 4'd0) && (r_msec_h == 4'd0) && (r_msec_l == 4'd1);

    // A valid load overrides any tick or start arriving in the same cycle.
    assign w_count      = (r_state == S_RUN) && i_cd_en && !i_pause && !w_load_ok;
    assign w_wrap       = w_count && (r_div == CNT_W'(TICK_DIV - 1));
    assign w_expire     = w_wrap && w_is_one;
    assign w_start_idle = (r_state == S_IDLE) && i_start && i_cd_en && !w_load_ok;

    // BCD decrement by one hundredth; 00.00 is never decremented.
    always_comb begin
        w_b0     = (r_msec_l == 4'd0);
        w_dec_ml = w_b0 ? 4'd9 : r_msec_l - 4'd1;
        w_b1     = w_b0 && (r_msec_h == 4'd0);
        w_dec_mh = w_b0 ? ((r_msec_h == 4'd0) ? 4'd9 : r_msec_h - 4'd1) : r_msec_h;
        w_b2     = w_b1 && (r_sec_l == 4'd0);
        w_dec_sl = w_b1 ? ((r_sec_l == 4'd0) ? 4'd9 : r_sec_l - 4'd1) : r_sec_l;
        w_dec_sh = w_b2 ? r_sec_h - 3'd1 : r_sec_h;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load_ok) begin
            w_state_next = S_IDLE;
        end else if (i_cd_en) begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) w_state_next = w_is_zero ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (i_pause) begin
                        w_state_next = S_PAUSED;
                    end else if (w_expire) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        w_state_next = S_RUN;
`else
                        w_state_next = S_DONE;
`endif
                    end
                end
                S_PAUSED: begin
                    if (i_start && !i_pause) w_state_next = S_RUN;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_div_next    = r_div;
        w_sec_h_next  = r_sec_h;
        w_sec_l_next  = r_sec_l;
        w_msec_h_next = r_msec_h;
        w_msec_l_next = r_msec_l;
        w_clk_out_next = w_wrap;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        w_time_out_next = (r_state == S_DONE) && r_time_out;
`else
        w_time_out_next = r_time_out;
`endif
        if (w_load_ok) begin
            w_div_next      = '0;
            w_sec_h_next    = i_load_sec_h;
            w_sec_l_next    = i_load_sec_l;
            w_msec_h_next   = i_load_msec_h;
            w_msec_l_next   = i_load_msec_l;
            w_time_out_next = 1'b0;
        end else if (w_start_idle) begin
            w_div_next = '0;
            if (w_is_zero) w_time_out_next = 1'b1;
        end else if (w_count) begin
            w_div_next = w_wrap ? '0 : r_div + CNT_W'(1);
            if (w_wrap) begin
                w_sec_h_next  = w_dec_sh;
                w_sec_l_next  = w_dec_sl;
                w_msec_h_next = w_dec_mh;
                w_msec_l_next = w_dec_ml;
            end
            if (w_expire) begin
                w_time_out_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                w_sec_h_next  = r_pre_sec_h;
                w_sec_l_next  = r_pre_sec_l;
                w_msec_h_next = r_pre_msec_h;
                w_msec_l_next = r_pre_msec_l;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div        <= '0;
            r_sec_h      <= '0;
            r_sec_l      <= '0;
            r_msec_h     <= '0;
            r_msec_l     <= '0;
            r_pre_sec_h  <= '0;
            r_pre_sec_l  <= '0;
            r_pre_msec_h <= '0;
            r_pre_msec_l <= '0;
            r_clk_out    <= 1'b0;
            r_time_out   <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_div      <= w_div_next;
            r_sec_h    <= w_sec_h_next;
            r_sec_l    <= w_sec_l_next;
            r_msec_h   <= w_msec_h_next;
            r_msec_l   <= w_msec_l_next;
            r_clk_out  <= w_clk_out_next;
            r_time_out <= w_time_out_next;
            r_load_err <= w_load_bad;
            if (w_load_ok) begin
                r_pre_sec_h  <= i_load_sec_h;
                r_pre_sec_l  <= i_load_sec_l;
                r_pre_msec_h <= i_load_msec_h;
                r_pre_msec_l <= i_load_msec_l;
            end
        end
    end

    assign o_time_sec_h  = r_sec_h;
    assign o_time_sec_l  = r_sec_l;
    assign o_time_msec_h = r_msec_h;
    assign o_time_msec_l = r_msec_l;
    assign o_clk_out     = r_clk_out;
    assign o_time_out    = r_time_out;
    assign o_load_err    = r_load_err;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed steps plus randomized runs against a centisecond-arithmetic model.
module tb_countdown_timer;
    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cd_en = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [2:0] ld_sh = '0;
    logic [3:0] ld_sl = '0, ld_mh = '0, ld_ml = '0;
    logic [2:0] t_sh;
    logic [3:0] t_sl, t_mh, t_ml;
    logic       clk_out, time_out, load_err;

    int n_asserts = 0;
    int n_fails   = 0;

    // Model: preset in hundredths, enabled running cycles since start, and run/pause/zero-start flags.
    int m_p = 0, m_n = 0;
    bit m_run = 0, m_paused = 0, m_done0 = 0, m_inc = 0;

    countdown_timer #(.TICK_DIV(TD), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cd_en(cd_en), .i_load(load), .i_start(start),
        .i_pause(pause), .i_load_sec_h(ld_sh), .i_load_sec_l(ld_sl), .i_load_msec_h(ld_mh),
        .i_load_msec_l(ld_ml), .o_time_sec_h(t_sh), .o_time_sec_l(t_sl), .o_time_msec_h(t_mh),
        .o_time_msec_l(t_ml), .o_clk_out(clk_out), .o_time_out(time_out), .o_load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dut_cs();
        return 32'(t_sh) * 1000 + 32'(t_sl) * 100 + 32'(t_mh) * 10 + 32'(t_ml);
    endfunction

    function automatic int exp_v();
        int k = m_n / TD;
        if (!m_run) return m_p;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        return m_p - (k % m_p);
`else
        return (k >= m_p) ? 0 : m_p - k;
`endif
    endfunction

    function automatic bit exp_clk();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        return m_inc && (m_n % TD == 0);
`else
        return m_inc && (m_n % TD == 0) && (m_n / TD <= m_p);
`endif
    endfunction

    function automatic bit exp_to();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        return m_done0 || (exp_clk() && ((m_n / TD) % m_p == 0));
`else
        return m_done0 || (m_run && (m_n / TD >= m_p));
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_model(input logic exp_err);
        chk("value", dut_cs(), 32'(exp_v()));
        chk("clk_out", 32'(clk_out), 32'(exp_clk()));
        chk("time_out", 32'(time_out), 32'(exp_to()));
        chk("load_err", 32'(load_err), 32'(exp_err));
    endtask

    task automatic cyc(input bit en, input bit pz, input bit st);
        cd_en = en; pause = pz; start = st; load = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        m_inc = 0;
        if (en) begin
            if (!m_run && !m_done0 && st) begin
                if (m_p == 0) m_done0 = 1;
                else begin m_run = 1; m_n = 0; end
            end else if (m_run && m_paused) begin
                if (st && !pz) m_paused = 0;
            end else if (m_run) begin
                if (pz) m_paused = 1;
                else begin m_n++; m_inc = 1; end
            end
        end
        chk_model(1'b0);
    endtask

    // Invalid loads are only issued while idle, so the model is left untouched for them.
    task automatic do_load(input logic [2:0] sh, input logic [3:0] sl, input logic [3:0] mh,
                           input logic [3:0] ml, input bit st, input bit en);
        bit ok;
        ld_sh = sh; ld_sl = sl; ld_mh = mh; ld_ml = ml;
        load = 1'b1; start = st; cd_en = en; pause = 1'b0;
        @(posedge clk); #1;
        load = 1'b0; start = 1'b0;
        ok = (sh <= 5) && (sl <= 9) && (mh <= 9) && (ml <= 9);
        m_inc = 0;
        if (ok) begin
            m_p = int'(sh) * 1000 + int'(sl) * 100 + int'(mh) * 10 + int'(ml);
            m_n = 0; m_run = 0; m_paused = 0; m_done0 = 0;
        end
        chk_model(!ok);
    endtask

    task automatic load_cs(input int v, input bit st);
        do_load(3'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), st, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_value"}, dut_cs(), 32'd0);
        chk({tag, "_clk_out"}, 32'(clk_out), 32'd0);
        chk({tag, "_time_out"}, 32'(time_out), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        int p, len;
        // Reset state
        #1;
        chk_all_zero("reset");
        #21;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset");

        // 00.05: five ticks then hold at expiry
        load_cs(5, 0);
        cyc(1, 0, 1);
        repeat (50) cyc(1, 0, 0);
        repeat (100) cyc(1, 0, 0);

        // 10.00 -> 09.99 full borrow chain
        load_cs(1000, 0);
        cyc(1, 0, 1);
        repeat (10) cyc(1, 0, 0);
        chk("borrow_sec_h", 32'(t_sh), 32'd0);
        chk("borrow_sec_l", 32'(t_sl), 32'd9);
        chk("borrow_msec_h", 32'(t_mh), 32'd9);
        chk("borrow_msec_l", 32'(t_ml), 32'd9);

        // Pause coincident with a wrap, held, release alone stays paused, then resume
        load_cs(50, 0);
        cyc(1, 0, 1);
        repeat (39) cyc(1, 0, 0);
        repeat (200) cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (5) cyc(1, 0, 0);
        chk("resume_value", dut_cs(), 32'd46);

        // Rejected loads leave digits and state alone
        load_cs(1234, 0);
        do_load(3'd6, 4'd0, 4'd0, 4'd0, 0, 1);
        cyc(1, 0, 0);
        do_load(3'd0, 4'd0, 4'd0, 4'd10, 0, 1);
        cyc(1, 0, 1);
        repeat (12) cyc(1, 0, 0);

        // Freeze with cd_en=0, then load+start on a would-be wrap cycle
        load_cs(1000, 0);
        cyc(1, 0, 1);
        repeat (19) cyc(1, 0, 0);
        repeat (100) cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        load_cs(2, 1);
        repeat (50) cyc(1, 0, 0);

        // Start from 00.00 goes straight to expiry; a load clears it
        load_cs(0, 0);
        cyc(1, 0, 1);
        repeat (20) cyc(1, 0, 1'($urandom_range(0, 1)));
        load_cs(3, 0);
        cyc(1, 0, 0);

        // Periodic expiry (auto-reload) or terminal expiry on a short preset
        load_cs(2, 0);
        cyc(1, 0, 1);
        repeat (60) cyc(1, 0, 0);

        // Reset mid-run
        load_cs(10, 0);
        cyc(1, 0, 1);
        repeat (15) cyc(1, 0, 0);
        rst_n = 1'b0;
        #2;
        chk_all_zero("midreset");
        m_p = 0; m_n = 0; m_run = 0; m_paused = 0; m_done0 = 0; m_inc = 0;
        @(posedge clk); #1;
        chk_all_zero("midreset_hold");
        rst_n = 1'b1;

        // Random valid loads across the full range
        for (int i = 0; i < 10; i++) load_cs(int'($urandom_range(0, 5999)), 0);

        // Randomized countdowns with gated enable
        for (int r = 0; r < 3; r++) begin
            p = int'($urandom_range(1, 120));
            len = p * TD * 4 / 3 + 40;
            load_cs(p, 0);
            cyc(1, 0, 1);
            for (int c = 0; c < len; c++) cyc($urandom_range(0, 3) != 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- BCD countdown timer, the down-counting counterpart of the stopwatch; shares its time-digit format (SS:CC, 00.00–59.99 s, 10 ms resolution) and control style.
- Loads a preset, counts down at a divided tick rate, supports pause/enable, and flags expiry on time_out.
- Sits beside the stopwatch and drives the same display/readout path.

Parameters:
- TICK_DIV, 1000000, clk cycles per 10 ms tick (100 MHz clk); benches use 10; legal range ≥2.
- CNT_W, 20, width of the tick divider counter; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cd_en  in  1  enable; 0 freezes divider and digits in any state
- load  in  1  one-cycle strobe; capture load_* digits as the preset
- start  in  1  one-cycle strobe; begin or resume countdown
- pause  in  1  level; 1 holds digits and divider while running
- load_sec_h  in  3  preset tens of seconds, 0–5
- load_sec_l  in  4  preset seconds, 0–9
- load_msec_h  in  4  preset tenths, 0–9
- load_msec_l  in  4  preset hundredths, 0–9
- time_sec_h  out  3  current tens of seconds
- time_sec_l  out  4  current seconds
- time_msec_h  out  4  current tenths
- time_msec_l  out  4  current hundredths
- clk_out  out  1  one-cycle pulse on every applied decrement tick
- time_out  out  1  expiry flag
- load_err  out  1  one-cycle pulse; rejected load

Behaviour:
- Reset (rst=0, async): state IDLE, all time digits 0, preset 0, divider 0, clk_out=0, time_out=0, load_err=0.
- States:
  - IDLE: value loaded, not counting.
  - RUN: counting.
  - PAUSED: counting suspended by pause.
  - DONE: countdown expired.
- Load (any state, cd_en ignored):
  - Valid digits (sec_h≤5, others ≤9): preset and time digits updated the next cycle, divider cleared, state→IDLE, time_out cleared.
  - Invalid digits: nothing changes; load_err=1 for one cycle.
- start in IDLE with nonzero value → RUN. start with value 00.00 → DONE, time_out=1.
- RUN:
  - When cd_en=1 and pause=0, the divider counts 0..TICK_DIV-1.
  - On wrap: decrement the 4-digit BCD value by one hundredth and pulse clk_out in the same cycle the digits update.
  - Borrow rules: msec_l 0→9 borrows from msec_h; msec_h 0→9 borrows from sec_l; sec_l 0→9 borrows from sec_h; sec_h 0→5 never occurs, because 00.00 is terminal.
  - Timing: the first decrement occurs TICK_DIV enabled cycles after start.
- RUN with pause=1 → PAUSED: divider and digits held. In PAUSED, pause=0 and start=1 together → RUN, divider resumes from its held value; pause=0 alone stays PAUSED.
- cd_en=0: divider and digits frozen in every state; state unchanged; start ignored.
- Expiry: the tick taking the value from 00.01 to 00.00 sets state DONE and time_out=1 in the same cycle; time_out stays high until load or reset. start in DONE is ignored.
- Simultaneous events:
  - load beats start in the same cycle; start is ignored.
  - load beats a coincident tick; the loaded value wins and no clk_out is issued.
  - pause beats a coincident tick wrap; no decrement, divider holds at TICK_DIV-1.
- Reset mid-operation returns immediately to the reset values above.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On expiry, reload the preset into the digits in the same cycle and remain in RUN.
  - time_out is a one-cycle pulse per expiry; DONE is never entered from RUN.
  - A start with a zero preset still goes to DONE with time_out held high.
- Undefined: stop at 00.00 in DONE with time_out held, as above.

Test Plan (TICK_DIV=10):
- Reset, then load 00.05 and start → clk_out pulses every 10 cycles; digits 00.04, 00.03 … 00.00 after 50 cycles; time_out=1 and held for a further 100 cycles with no clk_out.
- Load 10.00, start, run 1 tick → digits 09.99 (sec_h 1→0, sec_l 0→9, msec_h 0→9, msec_l 0→9).
- Load 00.50, start, pause=1 after 3 ticks for 200 cycles → digits hold 00.47, no clk_out; release pause and pulse start → next decrement after the remaining divider count, reaching 00.46.
- Load sec_h=6 → load_err pulses 1 cycle; digits and state unchanged. Load msec_l=10 → same.
- While running, cd_en=0 for 100 cycles → digits frozen; load 00.02 with start in the same cycle → state IDLE, digits 00.02, no countdown.
- With COUNTDOWN_AUTO_RELOAD_EN, load 00.02 and start → time_out pulses at cycles 20, 40, 60; digits cycle 00.01, 00.00→00.02 reload.
